// File: rtl/reaction_game_ctrl_pkg.sv
// rtl/reaction_game_ctrl_pkg.sv - shared state encoding for the reaction game controller
package reaction_game_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_WAIT   = 3'd2,
        S_GO     = 3'd3,
        S_RECORD = 3'd4,
        S_NEXT   = 3'd5,
        S_BEST   = 3'd6,
        S_DONE   = 3'd7
    } gameState_t;

endpackage

// File: rtl/reaction_game_ctrl_rise_detect.sv
// rtl/reaction_game_ctrl_rise_detect.sv - registered rising-edge detector
module rise_detect (
    input  logic Clock,
    input  logic CLRN,
    input  logic sigIn,
    output logic rise
);

    logic prev;

    // Pulse is registered, so the FSM sees it one cycle after the pin rises.
    always_ff @(posedge Clock or negedge CLRN) begin
        if (!CLRN) begin
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            prev <= sigIn;
            rise <= sigIn & ~prev;
        end
    end

endmodule

// File: rtl/reaction_game_ctrl.sv
// rtl/reaction_game_ctrl.sv - multi-round reaction game controller with best-score tracking
module reaction_game_ctrl
    import reaction_game_ctrl_pkg::*;
#(
    parameter int SCORE_W = 13,
    parameter int ADDR_W  = 3,
    parameter int ROUNDS  = 4
) (
    input  logic               Clock,
    input  logic               CLRN,
    input  logic               buttonStart,
    input  logic               buttonHit,
    input  logic               delayCounterDone,
    output logic               delayCounterEnable,
    output logic               delayCounterClear,
    output logic               ledRed,
    output logic               ledGreen,
    output logic               registerLoad,
    output logic [ADDR_W-1:0]  WriteAddress,
    output logic [SCORE_W-1:0] registerLoadData,
    output logic [ADDR_W-1:0]  roundNum,
    output logic               falseStart,
    output logic [SCORE_W-1:0] bestScore,
    output logic               gameDone
);

    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
    localparam logic [ADDR_W-1:0]  LAST_ROUND = ADDR_W'(ROUNDS);
    localparam logic [ADDR_W-1:0]  ROUND_ONE  = ADDR_W'(1);

    gameState_t         state;
    logic [SCORE_W-1:0] score;
    logic               hitRise;

    rise_detect uHitRise (
        .Clock (Clock),
        .CLRN  (CLRN),
        .sigIn (buttonHit),
        .rise  (hitRise)
    );

    always_ff @(posedge Clock or negedge CLRN) begin
        if (!CLRN) begin
            state      <= S_IDLE;
            score      <= '0;
            roundNum   <= ROUND_ONE;
            falseStart <= 1'b0;
            bestScore  <= SCORE_MAX;
        end else begin
            case (state)
                S_IDLE: if (buttonStart) state <= S_ARM;
                S_ARM: begin
                    score      <= '0;
                    falseStart <= 1'b0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // An early hit wins over a delay expiring in the same cycle.
                    if (hitRise) begin
                        falseStart <= 1'b1;
                        state      <= S_RECORD;
                    end else if (delayCounterDone) begin
                        state <= S_GO;
                    end
                end
                S_GO: begin
                    if (hitRise || score == SCORE_MAX) state <= S_RECORD;
                    else                               score <= score + 1'b1;
                end
                S_RECORD: begin
                    if (!falseStart && score != SCORE_MAX && score < bestScore)
                        bestScore <= score;
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (roundNum == LAST_ROUND) begin
                        state <= S_BEST;
                    end else begin
                        roundNum <= roundNum + 1'b1;
                        state    <= S_ARM;
                    end
                end
                S_BEST: state <= S_DONE;
                S_DONE: begin
                    if (buttonStart) begin
                        roundNum  <= ROUND_ONE;
                        bestScore <= SCORE_MAX;
                        state     <= S_ARM;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign delayCounterClear  = (state == S_ARM);
    assign delayCounterEnable = (state == S_WAIT);
    assign ledRed             = (state == S_ARM) || (state == S_WAIT);
    assign ledGreen           = (state == S_GO);
    assign gameDone           = (state == S_DONE);
    assign registerLoad       = (state == S_RECORD) || (state == S_BEST);
    assign WriteAddress       = (state == S_RECORD) ? roundNum : '0;
    assign registerLoadData   = (state == S_RECORD) ? (falseStart ? SCORE_MAX : score) :
                                (state == S_BEST)   ? bestScore : '0;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// tb/tb_reaction_game_ctrl.sv - randomized self-checking bench for reaction_game_ctrl
module tb_reaction_game_ctrl;

    localparam int SW   = 13;
    localparam int AW   = 3;
    localparam int NR   = 4;
    localparam int SMAX = (1 << SW) - 1;
    localparam int K_HIT = 0, K_FS = 1, K_TIMEOUT = 2, K_SIMUL = 3;

    logic          Clock = 1'b0;
    logic          CLRN = 1'b0;
    logic          buttonStart = 1'b0;
    logic          buttonHit = 1'b0;
    logic          manualDone = 1'b0;
    logic          delayCounterDone;
    logic          delayCounterEnable, delayCounterClear, ledRed, ledGreen;
    logic          registerLoad, falseStart, gameDone;
    logic [AW-1:0] WriteAddress, roundNum;
    logic [SW-1:0] registerLoadData, bestScore;

    reaction_game_ctrl #(.SCORE_W(SW), .ADDR_W(AW), .ROUNDS(NR)) dut (
        .Clock(Clock), .CLRN(CLRN), .buttonStart(buttonStart), .buttonHit(buttonHit),
        .delayCounterDone(delayCounterDone), .delayCounterEnable(delayCounterEnable),
        .delayCounterClear(delayCounterClear), .ledRed(ledRed), .ledGreen(ledGreen),
        .registerLoad(registerLoad), .WriteAddress(WriteAddress),
        .registerLoadData(registerLoadData), .roundNum(roundNum), .falseStart(falseStart),
        .bestScore(bestScore), .gameDone(gameDone)
    );

    always #5 Clock = ~Clock;

    // External random-delay counter stand-in.
    int dcnt = 0;
    int delayTarget = 1000000;
    always @(posedge Clock) begin
        if (delayCounterClear)       dcnt <= 0;
        else if (delayCounterEnable) dcnt <= dcnt + 1;
    end
    assign delayCounterDone = manualDone | (dcnt >= delayTarget);

    int checks = 0;
    int errors = 0;
    int expAddr[$];
    int expData[$];
    int greenCycles = 0;
    int round = 1;
    int best = SMAX;
    int kinds[NR];
    int js[NR];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit sel(input int w);
        case (w)
            0:       return delayCounterEnable;
            1:       return ledGreen;
            2:       return registerLoad;
            default: return gameDone;
        endcase
    endfunction

    task automatic waitFor(input int which, input int budget, input string name);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge Clock);
            seen = sel(which);
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
    endtask

    // Write scoreboard and per-cycle output consistency.
    always @(negedge Clock) begin
        if (CLRN) begin
            if (ledGreen) greenCycles++;
            check("ledOverlap", ledRed & ledGreen, 0);
            check("redDecode", ledRed, delayCounterClear | delayCounterEnable);
            if (registerLoad) begin
                if (expAddr.size() == 0) begin
                    check("unexpectedWrite", 1, 0);
                end else begin
                    check("writeAddr", WriteAddress, expAddr.pop_front());
                    check("writeData", registerLoadData, expData.pop_front());
                end
            end
        end
    end

    task automatic push(input int a, input int d);
        expAddr.push_back(a);
        expData.push_back(d);
    endtask

    task automatic pressStart();
        @(negedge Clock);
        buttonStart = 1'b1;
        @(negedge Clock);
        buttonStart = 1'b0;
        best  = SMAX;
        round = 1;
        check("startBestCleared", bestScore, SMAX);
        check("startRound", roundNum, 1);
        check("startArmClear", delayCounterClear, 1);
    endtask

    task automatic playRound(input int kind, input int j);
        int g0 = greenCycles;
        case (kind)
            K_HIT: begin
                delayTarget = $urandom_range(1, 8);
                waitFor(1, 300, "goEnter");
                repeat (j) @(posedge Clock);
                #1 buttonHit = 1'b1;
                push(round, j + 1);
                if (j + 1 < best) best = j + 1;
            end
            K_FS: begin
                delayTarget = 1000000;
                waitFor(0, 300, "waitEnter");
                buttonHit = 1'b1;
                push(round, SMAX);
            end
            K_TIMEOUT: begin
                delayTarget = $urandom_range(1, 8);
                waitFor(1, 300, "goEnter");
                push(round, SMAX);
            end
            default: begin
                delayTarget = 1000000;
                waitFor(0, 300, "waitEnter");
                buttonHit = 1'b1;
                @(posedge Clock);
                #1 manualDone = 1'b1;
                push(round, SMAX);
            end
        endcase
        if (round == NR) push(0, best);
        waitFor(2, SMAX + 500, "record");
        @(negedge Clock);
        check("falseStart", falseStart, (kind == K_FS || kind == K_SIMUL) ? 1 : 0);
        check("bestAfterRound", bestScore, best);
        case (kind)
            K_HIT:     check("goCycles", greenCycles - g0, j + 2);
            K_TIMEOUT: check("goCycles", greenCycles - g0, SMAX + 1);
            default:   check("goCycles", greenCycles - g0, 0);
        endcase
        buttonHit   = 1'b0;
        manualDone  = 1'b0;
        delayTarget = 1000000;
        round++;
    endtask

    task automatic playGame();
        pressStart();
        for (int r = 0; r < NR; r++) playRound(kinds[r], js[r]);
        waitFor(3, 20, "gameDone");
        check("gameBest", bestScore, best);
        check("writesDrained", expAddr.size(), 0);
    endtask

    task automatic randomGame();
        for (int r = 0; r < NR; r++) begin
            kinds[r] = ($urandom_range(0, 5) == 0) ? K_SIMUL : $urandom_range(0, 1);
            js[r]    = $urandom_range(0, 60);
        end
        playGame();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge Clock);
        check("rstBest", bestScore, SMAX);
        check("rstRound", roundNum, 1);
        check("rstAddr", WriteAddress, 0);
        check("rstData", registerLoadData, 0);
        check("rstLoad", registerLoad, 0);
        check("rstLeds", {ledRed, ledGreen, gameDone, falseStart}, 0);
        CLRN = 1'b1;
        repeat (2) @(negedge Clock);
        check("idleHolds", {ledRed, ledGreen, delayCounterEnable, delayCounterClear}, 0);

        kinds = '{K_HIT, K_FS, K_TIMEOUT, K_HIT};
        js    = '{24, 0, 0, 11};
        playGame();
        check("game1BestLiteral", bestScore, 12);

        kinds = '{K_HIT, K_FS, K_HIT, K_HIT};
        js    = '{24, 0, 39, 11};
        playGame();
        check("game2BestLiteral", bestScore, 12);

        kinds = '{K_SIMUL, K_HIT, K_FS, K_HIT};
        js    = '{0, $urandom_range(0, 40), 0, $urandom_range(0, 40)};
        playGame();

        pressStart();
        delayTarget = 3;
        waitFor(1, 300, "goEnterReset");
        repeat (5) @(negedge Clock);
        CLRN = 1'b0;
        #1;
        check("midResetGreen", ledGreen, 0);
        check("midResetLoad", registerLoad, 0);
        check("midResetRound", roundNum, 1);
        check("midResetBest", bestScore, SMAX);
        repeat (2) @(negedge Clock);
        delayTarget = 1000000;
        CLRN = 1'b1;
        @(negedge Clock);
        check("postResetIdle", {ledRed, ledGreen, gameDone}, 0);

        randomGame();
        randomGame();

        check("finalQueueEmpty", expAddr.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
